booth_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared N-bit radix-2 Booth multiplier datapath. It accepts multiply requests from two requesters and grants the datapath round-robin. It drives the datapath control strobes (load, reset-A, add/subtract, shift) for N iterations and returns the signed 2N-bit product with a one-cycle done to the owning requester.

---
 rtl/booth_arbiter.sv | 161 ++++++++++++++++
 tb/tb_booth_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_arbiter.sv
// booth_arbiter
//   Two-requester round-robin arbiter and sequencer for a shared N-bit
//   radix-2 Booth multiplier datapath. One multiply runs at a time. The
//   sequence is IDLE -> LOAD -> (EVAL, SHIFT) x N -> CAPT -> DONE -> IDLE.
//   The signed 2N-bit product is returned with a single-cycle done pulse
//   to the requester that owns the datapath.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req0/req1           level requests; sampled only in IDLE
//   a0,b0 / a1,b1       per-requester multiplicand / multiplier, latched at grant
//   gnt0/gnt1           owner indication, LOAD through DONE
//   done0/done1         one-cycle completion pulse to the owner (DONE state)
//   prod                registered signed product, updated on leaving CAPT
//   busy                high whenever the state is not IDLE
//   dp_multiplicando    latched multiplicand driven to the datapath
//   dp_multiplicador    latched multiplier driven to the datapath
//   dp_carga_qm         load Q (and clear Q[-1])      -- LOAD
//   dp_reset_a          clear accumulator A           -- LOAD
//   dp_carga_a          write A +/- M                 -- EVAL, Booth pair 01/10
//   dp_resta            select subtract for dp_carga_a (pair 10)
//   dp_desplaza_aq      arithmetic shift of {A,Q,Q[-1]} -- SHIFT
//   dp_q0, dp_q_menos1  datapath Q[0] and Q[-1]
//   dp_result           datapath {A,Q}
`timescale 1ns/1ps
module booth_arbiter #(
  parameter int N = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [N-1:0]          a0,
  input  logic [N-1:0]          b0,
  input  logic [N-1:0]          a1,
  input  logic [N-1:0]          b1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic signed [2*N-1:0] prod,
  output logic                  busy,
  output logic [N-1:0]          dp_multiplicando,
  output logic [N-1:0]          dp_multiplicador,
  output logic                  dp_carga_qm,
  output logic                  dp_reset_a,
  output logic                  dp_carga_a,
  output logic                  dp_resta,
  output logic                  dp_desplaza_aq,
  input  logic                  dp_q0,
  input  logic                  dp_q_menos1,
  input  logic [2*N-1:0]        dp_result
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    CAPT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic             owner;      // 0: requester 0 owns the datapath, 1: requester 1
  logic             last;       // last-served requester, tie breaker
  logic [CNT_W-1:0] cnt;        // Booth iterations remaining
  logic             grant_sel;  // requester chosen if a grant happens this cycle

  // A lone request wins; on a tie the requester not served last wins.
  function automatic logic pick_owner(input logic r0, input logic r1,
                                      input logic last_served);
    return r1 & (~r0 | ~last_served);
  endfunction

  assign grant_sel = pick_owner(req0, req1, last);

  // Booth recoding: pair (Q0,Q-1) = 10 subtracts M, 01 adds M, 00/11 idle.
  assign dp_carga_a = (state == EVAL) & (dp_q0 ^ dp_q_menos1);
  assign dp_resta   = (state == EVAL) & dp_q0 & ~dp_q_menos1;

  // Every other output is registered and reflects the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= 1'b0;
      last             <= 1'b1;
      cnt              <= '0;
      prod             <= '0;
      dp_multiplicando <= '0;
      dp_multiplicador <= '0;
      gnt0             <= 1'b0;
      gnt1             <= 1'b0;
      done0            <= 1'b0;
      done1            <= 1'b0;
      busy             <= 1'b0;
      dp_carga_qm      <= 1'b0;
      dp_reset_a       <= 1'b0;
      dp_desplaza_aq   <= 1'b0;
    end else begin
      done0          <= 1'b0;
      done1          <= 1'b0;
      dp_carga_qm    <= 1'b0;
      dp_reset_a     <= 1'b0;
      dp_desplaza_aq <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner            <= grant_sel;
            last             <= grant_sel;
            dp_multiplicando <= grant_sel ? a1 : a0;
            dp_multiplicador <= grant_sel ? b1 : b0;
            gnt0             <= ~grant_sel;
            gnt1             <= grant_sel;
            busy             <= 1'b1;
            dp_carga_qm      <= 1'b1;
            dp_reset_a       <= 1'b1;
            state            <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= CNT_W'(N);
          state <= EVAL;
        end
        EVAL: begin
          dp_desplaza_aq <= 1'b1;
          state          <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= CAPT;
          end else begin
            state <= EVAL;
          end
        end
        CAPT: begin
          prod  <= dp_result;
          done0 <= ~owner;
          done1 <= owner;
          state <= DONE;
        end
        DONE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_arbiter.sv
// tb_booth_arbiter
//   Bench for booth_arbiter (N=3). A behavioural Booth datapath with an
//   (N+1)-bit accumulator answers the arbiter's strobes. Directed vectors
//   with hand-computed products are applied from a table, followed by
//   hand-written sequences for strobe timing, tie-break, fairness, reset
//   mid-operation and operand isolation.
`timescale 1ns/1ps
module tb_booth_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           req0, req1;
  logic [N-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, done0, done1, busy;
  logic [2*N-1:0] prod;
  logic [N-1:0]   dp_multiplicando, dp_multiplicador;
  logic           dp_carga_qm, dp_reset_a, dp_carga_a, dp_resta, dp_desplaza_aq;
  logic           dp_q0, dp_q_menos1;
  logic [2*N-1:0] dp_result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  booth_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .prod(prod), .busy(busy),
    .dp_multiplicando(dp_multiplicando), .dp_multiplicador(dp_multiplicador),
    .dp_carga_qm(dp_carga_qm), .dp_reset_a(dp_reset_a), .dp_carga_a(dp_carga_a),
    .dp_resta(dp_resta), .dp_desplaza_aq(dp_desplaza_aq),
    .dp_q0(dp_q0), .dp_q_menos1(dp_q_menos1), .dp_result(dp_result)
  );

  // Booth datapath: A is one bit wider so that subtracting the most
  // negative multiplicand cannot overflow.
  logic signed [N:0] acc;
  logic [N-1:0]      q;
  logic              qm1;
  logic signed [N:0] m_ext;

  assign m_ext       = {dp_multiplicando[N-1], dp_multiplicando};
  assign dp_q0       = q[0];
  assign dp_q_menos1 = qm1;
  assign dp_result   = {acc[N-1:0], q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      q   <= '0;
      qm1 <= 1'b0;
    end else begin
      if (dp_carga_qm) begin
        q   <= dp_multiplicador;
        qm1 <= 1'b0;
      end
      if (dp_reset_a) begin
        acc <= '0;
      end else if (dp_carga_a) begin
        acc <= dp_resta ? acc - m_ext : acc + m_ext;
      end else if (dp_desplaza_aq) begin
        {acc, q, qm1} <= {acc[N], acc, q};
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One operation from IDLE (cycle 0 = now) through cycle 10.
  task automatic run_op(input string tag, input bit who, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [2*N-1:0] exp_p);
    int done_cyc = -1;
    bit gnt_ok = 1'b1;
    if (!who) begin a0 = a; b0 = b; req0 = 1'b1; end
    else      begin a1 = a; b1 = b; req1 = 1'b1; end
    for (int c = 1; c <= 12 && done_cyc < 0; c++) begin
      tick();
      if ((who ? gnt1 : gnt0) !== 1'b1 || (who ? gnt0 : gnt1) !== 1'b0) gnt_ok = 1'b0;
      if ((who ? done1 : done0) === 1'b1) done_cyc = c;
    end
    if (!who) req0 = 1'b0; else req1 = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, 9);
    check({tag, "_gnt"}, gnt_ok, 1);
    check({tag, "_prod"}, prod, exp_p);
    tick();
    check({tag, "_idle_after"}, {busy, gnt0, gnt1, done0, done1}, 0);
  endtask

  typedef struct {
    bit             who;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] strobe_exp[8];
    int d0c, d1c, nd;
    int own[4];
    int dcy[4];
    logic [2*N-1:0] p0, p1;
    bit excl_ok;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #2;
    check("reset_ctrl", {gnt0, gnt1, done0, done1, busy, dp_carga_qm, dp_reset_a,
                         dp_carga_a, dp_resta, dp_desplaza_aq}, 0);
    check("reset_prod", prod, 0);
    check("reset_operands", {dp_multiplicando, dp_multiplicador}, 0);
    do_reset();

    // Directed table: requester, a, b, hand-computed product.
    tbl[0] = '{1'b0, 3'b011, 3'b110, 6'b111010};  //  3 * -2 = -6
    tbl[1] = '{1'b1, 3'b111, 3'b111, 6'b000001};  // -1 * -1 =  1
    tbl[2] = '{1'b0, 3'b100, 3'b011, 6'b110100};  // -4 *  3 = -12
    tbl[3] = '{1'b1, 3'b010, 3'b100, 6'b111000};  //  2 * -4 = -8
    tbl[4] = '{1'b0, 3'b000, 3'b101, 6'b000000};  //  0 * -3 =  0
    tbl[5] = '{1'b1, 3'b100, 3'b100, 6'b010000};  // -4 * -4 = 16
    tbl[6] = '{1'b0, 3'b011, 3'b011, 6'b001001};  //  3 *  3 =  9
    tbl[7] = '{1'b1, 3'b101, 3'b010, 6'b111010};  // -3 *  2 = -6
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].who, tbl[i].a, tbl[i].b, tbl[i].p);
    end

    // Strobe sequence for b0=010: {carga_qm, reset_a, carga_a, resta, desplaza}
    strobe_exp[1] = 5'b11000; strobe_exp[2] = 5'b00000; strobe_exp[3] = 5'b00001;
    strobe_exp[4] = 5'b00110; strobe_exp[5] = 5'b00001; strobe_exp[6] = 5'b00100;
    strobe_exp[7] = 5'b00001;
    a0 = 3'b011; b0 = 3'b010; req0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c <= 7)
        check($sformatf("strobe_c%0d", c),
              {dp_carga_qm, dp_reset_a, dp_carga_a, dp_resta, dp_desplaza_aq}, strobe_exp[c]);
      if (c == 9) begin
        check("strobe_done0", done0, 1);
        check("strobe_prod", prod, 6'b000110);
        req0 = 1'b0;
      end
    end

    // Tie after reset: requester 0 first, requester 1 granted from cycle 10.
    do_reset();
    a0 = 3'b100; b0 = 3'b100; a1 = 3'b011; b1 = 3'b011;
    req0 = 1'b1; req1 = 1'b1;
    d0c = -1; d1c = -1; p0 = '0; p1 = '0; excl_ok = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if ((gnt0 & gnt1) || (done0 & done1)) excl_ok = 1'b0;
      if (c == 11) check("tie_gnt1_c11", {gnt0, gnt1}, 2'b01);
      if (done0 === 1'b1) begin d0c = c; p0 = prod; req0 = 1'b0; end
      if (done1 === 1'b1) begin d1c = c; p1 = prod; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie_done0_cycle", d0c, 9);
    check("tie_prod0", p0, 6'b010000);
    check("tie_done1_cycle", d1c, 19);
    check("tie_prod1", p1, 6'b001001);
    check("tie_exclusive", excl_ok, 1);

    // Fairness: both requests stay high, owners must alternate.
    do_reset();
    a0 = 3'b001; b0 = 3'b001; a1 = 3'b001; b1 = 3'b001;
    req0 = 1'b1; req1 = 1'b1;
    nd = 0;
    for (int k = 0; k < 4; k++) begin own[k] = -1; dcy[k] = -1; end
    for (int c = 1; c <= 45 && nd < 4; c++) begin
      tick();
      if (done0 === 1'b1 || done1 === 1'b1) begin
        own[nd] = done1 ? 1 : 0;
        dcy[nd] = c;
        nd++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fair_owner%0d", k), own[k], k % 2);
      check($sformatf("fair_cycle%0d", k), dcy[k], 9 + 10 * k);
    end

    // Reset during SHIFT at cycle 5, then requester 1 alone.
    do_reset();
    tick();
    a0 = 3'b011; b0 = 3'b110; req0 = 1'b1;
    repeat (5) tick();
    check("rst_pre_shift", {busy, dp_desplaza_aq}, 2'b11);
    reset = 1'b1;
    #1;
    check("rst_async_ctrl", {gnt0, gnt1, done0, done1, busy, dp_carga_qm, dp_reset_a,
                             dp_carga_a, dp_resta, dp_desplaza_aq}, 0);
    check("rst_async_data", {prod, dp_multiplicando, dp_multiplicador}, 0);
    req0 = 1'b0;
    a1 = 3'b010; b1 = 3'b011; req1 = 1'b1;
    tick();
    check("rst_held_no_done", {done0, done1, gnt0, gnt1}, 0);
    #1;
    reset = 1'b0;
    d1c = -1; excl_ok = 1'b1;
    for (int c = 1; c <= 12 && d1c < 0; c++) begin
      tick();
      if (gnt0 !== 1'b0 || done0 !== 1'b0) excl_ok = 1'b0;
      if (done1 === 1'b1) d1c = c;
    end
    req1 = 1'b0;
    check("rst_req1_done_cycle", d1c, 9);
    check("rst_req1_prod", prod, 6'b000110);
    check("rst_no_owner0", excl_ok, 1);
    tick();

    // Operand isolation: a0/b0 change right after the grant.
    a0 = 3'b011; b0 = 3'b011; req0 = 1'b1;
    tick();
    a0 = 3'b111; b0 = 3'b101;
    d0c = -1;
    for (int c = 2; c <= 12 && d0c < 0; c++) begin
      tick();
      if (c == 2) check("iso_latched_ops", {dp_multiplicando, dp_multiplicador}, 6'b011011);
      if (done0 === 1'b1) d0c = c;
    end
    req0 = 1'b0;
    check("iso_done_cycle", d0c, 9);
    check("iso_prod", prod, 6'b001001);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
